// File: rtl/key_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : key_pkg                                                         |
// | Purpose  : Shared definitions for the push-button debounce stage: FSM      |
// |            state encoding and default qualification constants.            |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package key_pkg;

  // 10 ms at the 100 MHz board oscillator.
  localparam int KEY_STABLE_10MS = 1_000_000;
  localparam int KEY_CNT_W       = 20;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } key_state_e;

endpackage : key_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sync_2ff                                                        |
// | Purpose  : Two-flop synchroniser bringing an asynchronous level into the   |
// |            clock domain. Both stages clear to 0 on reset.                  |
// | Ports    : clk_i  - destination clock (rising edge)                        |
// |            rst_ni - asynchronous active-low reset                          |
// |            d_i    - asynchronous input level                               |
// |            q_o    - synchronised level (second stage)                      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : key_debounce                                                    |
// | Purpose  : Synchronises one raw push-button, accepts a new level only      |
// |            after it has been stable for STABLE_CYCLES clocks, and emits    |
// |            the clean level plus one-cycle press/release strobes.          |
// | Ports    : cp          - system clock (rising edge)                        |
// |            rd          - asynchronous active-low reset                     |
// |            key_in      - raw, bouncing, asynchronous key level             |
// |            key_level   - debounced level (direct flop output)              |
// |            key_press   - one-cycle strobe on key_level 0->1                |
// |            key_release - one-cycle strobe on key_level 1->0                |
// |            busy        - high while a level change is being qualified      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module key_debounce
  import key_pkg::*;
#(
  parameter int STABLE_CYCLES = KEY_STABLE_10MS,
  parameter int CNT_W         = KEY_CNT_W
) (
  input  logic cp,
  input  logic rd,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic busy
);

  // Count value on which the new level is committed; the counter starts at 0
  // on the cycle the WAIT state is entered.
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(STABLE_CYCLES - 1);

  logic             key_sync;
  key_state_e       state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             level_q,   level_d;
  logic             press_q,   press_d;
  logic             release_q, release_d;

  sync_2ff u_sync (
    .clk_i  (cp),
    .rst_ni (rd),
    .d_i    (key_in),
    .q_o    (key_sync)
  );

  always_ff @(posedge cp or negedge rd) begin
    if (!rd) begin
      state_q   <= IDLE_LOW;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // The counter is cleared on every state exit, so it can never pass
  // c_cnt_last and no wrap handling is needed.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;

    case (state_q)
      IDLE_LOW: begin
        if (key_sync) begin
          state_d = WAIT_HIGH;
          cnt_d   = '0;
        end
      end

      WAIT_HIGH: begin
        if (!key_sync) begin
          // Bounce: drop the pending change without a strobe.
          state_d = IDLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == c_cnt_last) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      IDLE_HIGH: begin
        if (!key_sync) begin
          state_d = WAIT_LOW;
          cnt_d   = '0;
        end
      end

      WAIT_LOW: begin
        if (key_sync) begin
          state_d = IDLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == c_cnt_last) begin
          state_d   = IDLE_LOW;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE_LOW;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  // key_level feeds a downstream clock input, so it comes straight from a flop.
  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign busy        = (state_q == WAIT_HIGH) || (state_q == WAIT_LOW);

endmodule : key_debounce
`default_nettype wire

// File: tb/tb_key_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_key_debounce                                                 |
// | Purpose  : Directed self-checking bench for key_debounce with a 8-cycle    |
// |            stable window, including a model of the downstream mod-4        |
// |            counter clocked on the falling edge of key_level.               |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_key_debounce;

  localparam int STABLE = 8;

  logic cp = 1'b0;
  logic rd = 1'b1;
  logic key_in = 1'b0;
  logic key_level, key_press, key_release, busy;

  int passed = 0;
  int total  = 0;

  key_debounce #(.STABLE_CYCLES(STABLE), .CNT_W(4)) dut (
    .cp          (cp),
    .rd          (rd),
    .key_in      (key_in),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .busy        (busy)
  );

  always #5 cp = ~cp;

  // Downstream mod-4 ripple counter: advances on the falling edge of x.
  logic [1:0] ctr;
  logic       z;
  always @(negedge key_level or negedge rd) begin
    if (!rd) ctr <= 2'd0;
    else     ctr <= ctr + 2'd1;
  end
  assign z = (ctr == 2'd3) && key_level;

  // Advance to 1 ns after the next rising edge.
  task automatic step();
    @(posedge cp);
    #1;
  endtask

  // Drive key_in low long enough to settle without checking.
  task automatic settle_low();
    key_in = 1'b0;
    repeat (14) step();
  endtask

  task automatic test_reset();
    #3 rd = 1'b0;
    #1;
    total++;
    if ({key_level, key_press, key_release, busy} !== 4'b0000)
      $display("FAIL reset_assert: outputs=%b required=0000", {key_level, key_press, key_release, busy});
    else passed++;
    step();
    step();
    rd = 1'b1;
    repeat (4) step();
    total++;
    if ({key_level, key_press, key_release, busy} !== 4'b0000)
      $display("FAIL reset_idle: outputs=%b required=0000", {key_level, key_press, key_release, busy});
    else passed++;
  endtask

  // After the i-th step following the change, the commit is at i = STABLE+3
  // (sampling edge k is step 1, commit after edge k+2+STABLE).
  task automatic test_clean_press();
    int busy_cnt = 0;
    int press_cnt = 0;
    key_in = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (busy) busy_cnt++;
      if (key_press) press_cnt++;
      if (i == 10) begin
        total++;
        if (key_level !== 1'b0) $display("FAIL press_early: level=%b required=0 at step %0d", key_level, i);
        else passed++;
      end
      if (i == 11) begin
        total++;
        if ({key_level, key_press} !== 2'b11) $display("FAIL press_commit: level,press=%b required=11", {key_level, key_press});
        else passed++;
      end
      if (i == 12) begin
        total++;
        if ({key_level, key_press} !== 2'b10) $display("FAIL press_width: level,press=%b required=10", {key_level, key_press});
        else passed++;
      end
    end
    total++;
    if (busy_cnt != STABLE) $display("FAIL press_busy: busy cycles=%0d required=%0d", busy_cnt, STABLE);
    else passed++;
    total++;
    if (press_cnt != 1) $display("FAIL press_count: strobes=%0d required=1", press_cnt);
    else passed++;
  endtask

  task automatic test_async_reset();
    #3 rd = 1'b0;
    #1;
    total++;
    if ({key_level, key_press, key_release, busy} !== 4'b0000)
      $display("FAIL async_reset: outputs=%b required=0000", {key_level, key_press, key_release, busy});
    else passed++;
    step();
    key_in = 1'b0;
    step();
    rd = 1'b1;
    repeat (4) step();
    total++;
    if ({key_level, key_press, key_release, busy} !== 4'b0000)
      $display("FAIL async_reset_idle: outputs=%b required=0000", {key_level, key_press, key_release, busy});
    else passed++;
  endtask

  task automatic test_bounce();
    int early_strobes = 0;
    int press_cnt = 0;
    int rel_cnt = 0;
    for (int b = 0; b < 4; b++) begin
      key_in = (b % 2 == 0);
      repeat (3) begin
        step();
        if (key_press || key_release || key_level) early_strobes++;
      end
    end
    key_in = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      step();
      if (key_press) press_cnt++;
      if (key_release) rel_cnt++;
      if (i == 10) begin
        total++;
        if (key_level !== 1'b0) $display("FAIL bounce_early: level=%b required=0", key_level);
        else passed++;
      end
      if (i == 11) begin
        total++;
        if ({key_level, key_press} !== 2'b11) $display("FAIL bounce_commit: level,press=%b required=11", {key_level, key_press});
        else passed++;
      end
    end
    total++;
    if (early_strobes != 0) $display("FAIL bounce_reject: activity=%0d required=0", early_strobes);
    else passed++;
    total++;
    if (press_cnt != 1 || rel_cnt != 0) $display("FAIL bounce_strobes: press=%0d release=%0d required 1/0", press_cnt, rel_cnt);
    else passed++;
  endtask

  task automatic test_release();
    int busy_cnt = 0;
    int rel_cnt = 0;
    key_in = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (busy) busy_cnt++;
      if (key_release) rel_cnt++;
      if (key_press) begin
        total++;
        $display("FAIL release_press: press=1 required=0 at step %0d", i);
      end
      if (i == 10) begin
        total++;
        if (key_level !== 1'b1) $display("FAIL release_early: level=%b required=1", key_level);
        else passed++;
      end
      if (i == 11) begin
        total++;
        if ({key_level, key_release} !== 2'b01) $display("FAIL release_commit: level,release=%b required=01", {key_level, key_release});
        else passed++;
      end
    end
    total++;
    if (rel_cnt != 1) $display("FAIL release_count: strobes=%0d required=1", rel_cnt);
    else passed++;
    total++;
    if (busy_cnt != STABLE) $display("FAIL release_busy: busy cycles=%0d required=%0d", busy_cnt, STABLE);
    else passed++;
  endtask

  task automatic test_short_glitch();
    int activity = 0;
    key_in = 1'b1;
    repeat (5) begin
      step();
      if (key_level || key_press || key_release) activity++;
    end
    key_in = 1'b0;
    repeat (12) begin
      step();
      if (key_level || key_press || key_release) activity++;
    end
    total++;
    if (activity != 0) $display("FAIL glitch_reject: activity=%0d required=0", activity);
    else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL glitch_busy: busy=%b required=0", busy);
    else passed++;
  endtask

  task automatic test_reset_mid_qual();
    int press_cnt = 0;
    int press_step = 0;
    key_in = 1'b1;
    // cnt reaches 5 after edge k+7, i.e. after the 8th step.
    repeat (8) step();
    total++;
    if (busy !== 1'b1) $display("FAIL midqual_busy: busy=%b required=1", busy);
    else passed++;
    rd = 1'b0;
    repeat (3) begin
      step();
      if (key_press || key_level || busy) press_cnt++;
    end
    total++;
    if (press_cnt != 0) $display("FAIL midqual_in_reset: activity=%0d required=0", press_cnt);
    else passed++;
    rd = 1'b1;
    press_cnt = 0;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (key_press) begin
        press_cnt++;
        press_step = i;
      end
    end
    total++;
    if (press_cnt != 1 || press_step != 11)
      $display("FAIL midqual_press: strobes=%0d at step %0d required 1 at step 11", press_cnt, press_step);
    else passed++;
  endtask

  task automatic test_counter();
    key_in = 1'b0;
    rd = 1'b0;
    step();
    rd = 1'b1;
    step();
    total++;
    if (ctr !== 2'd0) $display("FAIL counter_init: count=%0d required=0", ctr);
    else passed++;
    for (int p = 0; p < 4; p++) begin
      logic [1:0] exp_cnt;
      key_in = 1'b1;
      repeat (12) step();
      exp_cnt = 2'(p);
      total++;
      if (ctr !== exp_cnt || z !== (p == 3))
        $display("FAIL counter_press%0d: count=%0d z=%b required count=%0d z=%b", p, ctr, z, exp_cnt, (p == 3));
      else passed++;
      key_in = 1'b0;
      repeat (12) step();
      exp_cnt = 2'(p + 1);
      total++;
      if (ctr !== exp_cnt || z !== 1'b0)
        $display("FAIL counter_release%0d: count=%0d z=%b required count=%0d z=0", p, ctr, z, exp_cnt);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_async_reset();
    test_bounce();
    test_release();
    test_short_glitch();
    test_reset_mid_qual();
    settle_low();
    test_counter();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_key_debounce
`default_nettype wire

// File: doc/key_debounce.md
# key_debounce

Debounce and edge-pulse stage for one raw push-button on the EGO1 board. Its clean output replaces the raw S1 level on the `x` input of the mod-4 JK ripple counter, which counts on the falling edge of `x`. Mechanical bounce therefore advances the counter exactly once per physical press/release. The block synchronises the raw key, qualifies each level change over a programmable stable window, and emits the debounced level plus one-cycle press/release strobes.

## Interface
- `STABLE_CYCLES`, default 1_000_000: consecutive cycles the synchronised key must hold a new level before it is accepted. This is 10 ms at 100 MHz. Legal range is ≥ 2.
- `CNT_W`, default 20: counter width. Must satisfy 2^CNT_W ≥ STABLE_CYCLES.

Ports:
- `cp`  in  1  system clock, 100 MHz board oscillator. All flops are on the rising edge.
- `rd`  in  1  reset, asynchronous, active-low.
- `key_in`  in  1  raw button level, active-high. It is asynchronous to `cp` and bounces.
- `key_level`  out  1  debounced level. This drives the counter's `x`.
- `key_press`  out  1  one-cycle strobe when `key_level` goes 0→1.
- `key_release`  out  1  one-cycle strobe when `key_level` goes 1→0. This coincides with the counter's active edge.
- `busy`  out  1  high while a level change is being qualified (WAIT states).

## Operation
- **Synchroniser.** Two flops, `s1`←`key_in` and `s2`←`s1`. The FSM uses only `s2`.
- **FSM states:** IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW.
  - IDLE_LOW: `s2`=1 → WAIT_HIGH, cnt←0.
  - WAIT_HIGH, `s2`=0: back to IDLE_LOW, cnt←0. This is a bounce reject; no strobe.
  - WAIT_HIGH, `s2`=1, cnt<STABLE_CYCLES−1: cnt←cnt+1.
  - WAIT_HIGH, `s2`=1, cnt=STABLE_CYCLES−1: go to IDLE_HIGH, `key_level`←1, `key_press`←1 for one cycle, cnt←0.
  - IDLE_HIGH and WAIT_LOW mirror the above with polarity inverted, producing `key_release`.
- **Outputs.** `key_level` is registered and changes only on commit. `busy` = 1 in WAIT states. The strobes are registered and never both high in the same cycle.
- **Counter.** The counter saturates by construction; no wrap can occur, because it is cleared on every state exit.
- **Reset.** `rd`=0 forces IDLE_LOW, cnt=0, `s1`=`s2`=0, and all outputs 0, immediately and independent of `cp`.
  - Reset mid-WAIT discards the pending change; no strobe is emitted.
  - If the key is held high across reset release, it is qualified normally and yields exactly one `key_press`.

## Timing
- **Press latency.** Assume `key_in` is stable high from sampling edge k. Then WAIT_HIGH is entered at edge k+2, and `key_level`/`key_press` assert after edge k+2+STABLE_CYCLES. The same latency applies to release.
- **Strobe width.** `key_press` and `key_release` are exactly one `cp` cycle wide.
- **Bounce handling.** Any `s2` glitch shorter than STABLE_CYCLES restarts qualification from cnt=0.
- **Throughput.** The minimum spacing between a committed press and the next committed release is STABLE_CYCLES+1 cycles.
- **Downstream hazard.** `key_level` is glitch-free because it is a direct flop output. This is mandatory, since the counter uses it as a clock.

## Structure
- Shared package `key_pkg` holds:
  - the 2-bit state encoding (IDLE_LOW=0, WAIT_HIGH=1, IDLE_HIGH=2, WAIT_LOW=3);
  - default constants `KEY_STABLE_10MS`=1_000_000 and `KEY_CNT_W`=20.
- Sub-module `sync_2ff` contains the two-flop synchroniser with async active-low reset to 0. It is reused for the other board switches.
- The top-level integration instantiates `key_debounce` on S1 and feeds `key_level` into the counter's `x`, sharing `rd`.

## Test plan
All scenarios run with STABLE_CYCLES=8.
- **Reset.** `rd`=0 mid-run → all outputs 0 asynchronously, before the next `cp` edge. `rd`=1 with `key_in`=0 → outputs remain 0.
- **Clean press.** `key_in` 0→1 held 20 cycles → `key_level`=1 exactly 10 edges after the first sampling edge. `key_press` is high 1 cycle; `busy` is high 8 cycles before commit.
- **Bounce.** `key_in` toggles 1,0,1,0 at 3-cycle intervals, then holds 1 → single `key_press`, timed 10 edges after the final stable rise. No `key_release`.
- **Short glitch.** `key_in` high for 5 cycles, then 0 → `key_level` stays 0, no strobes, `busy` returns to 0.
- **Release and counter.** After a press, `key_in`→0 held 20 cycles → `key_release` 1 cycle. Four full press/release pairs advance the downstream counter 00→01→10→11→00, with `z`=1 only while count=11 and `key_level`=1.
- **Reset mid-qualification.** `rd` pulsed low during WAIT_HIGH at cnt=5, with key still high → no strobe during reset. After release, one `key_press` occurs 10 edges later.
